// File: rtl/mem_access_stage_if.sv
// Data-memory request/response bus between the MEM pipeline stage and the data memory.
// The stage is the master and the memory is the slave.
interface mem_access_stage_if;
  logic        mem_req;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata;
  logic        mem_ack;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_rdata,
    input  mem_ack
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_rdata,
    output mem_ack
  );
endinterface

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: resolves branches, runs a variable-latency data-memory access
// with misalignment and timeout detection, and drives the MEM/WB register.
module mem_access_stage #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        valid_in,
  input  logic [1:0]  WB,
  input  logic        Branch,
  input  logic        MemWrite,
  input  logic        MemRead,
  input  logic [63:0] Adder_Result,
  input  logic        ALU_Zero,
  input  logic [63:0] ALU_Result,
  input  logic [63:0] Forward_B_Mux_Result,
  input  logic [4:0]  rd,
  output logic        PCSrc,
  output logic [63:0] Branch_Target,
  output logic        mem_stall,
  mem_access_stage_if.master mem,
  output logic        mem_err,
  output logic [1:0]  WB_Out,
  output logic [63:0] Read_Data_Out,
  output logic [63:0] ALU_Result_Out,
  output logic [4:0]  rd_out,
  output logic        valid_out
);

  typedef enum logic {IDLE, WAIT} state_t;

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  logic [7:0] wait_cnt;
  logic [1:0] wb_lat;
  logic [4:0] rd_lat;
  logic       memop;
  logic       aligned;
  logic       timeout_hit;

  assign memop         = valid_in & (MemRead | MemWrite);
  assign aligned       = (ALU_Result[2:0] == 3'b000);
  assign timeout_hit   = (wait_cnt == TIMEOUT_LAST);
  assign PCSrc         = valid_in & Branch & ALU_Zero;
  assign Branch_Target = Adder_Result;

  // The final WAIT cycle (ack or timeout) releases the stall so the pipeline advances with the result.
  always_comb begin
    mem_stall = 1'b0;
    case (state)
      IDLE: mem_stall = memop & aligned;
      WAIT: mem_stall = ~mem.mem_ack & ~timeout_hit;
    endcase
  end

  // A bubble (valid_out=0, WB_Out=0) is the default every edge; only completed instructions override it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      wait_cnt       <= '0;
      wb_lat         <= '0;
      rd_lat         <= '0;
      mem.mem_req    <= 1'b0;
      mem.mem_we     <= 1'b0;
      mem.mem_addr   <= '0;
      mem.mem_wdata  <= '0;
      mem_err        <= 1'b0;
      WB_Out         <= '0;
      Read_Data_Out  <= '0;
      ALU_Result_Out <= '0;
      rd_out         <= '0;
      valid_out      <= 1'b0;
    end else begin
      mem_err   <= 1'b0;
      valid_out <= 1'b0;
      WB_Out    <= '0;
      case (state)
        IDLE: begin
          if (memop && aligned) begin
            state         <= WAIT;
            wait_cnt      <= '0;
            mem.mem_req   <= 1'b1;
            mem.mem_we    <= MemWrite;
            mem.mem_addr  <= ALU_Result;
            mem.mem_wdata <= Forward_B_Mux_Result;
            wb_lat        <= WB;
            rd_lat        <= rd;
          end else if (memop) begin
            mem_err <= 1'b1;
          end else if (valid_in) begin
            valid_out      <= 1'b1;
            WB_Out         <= WB;
            Read_Data_Out  <= '0;
            ALU_Result_Out <= ALU_Result;
            rd_out         <= rd;
          end
        end
        WAIT: begin
          // Ack is tested first so a response on the last allowed cycle still completes.
          if (mem.mem_ack) begin
            state          <= IDLE;
            mem.mem_req    <= 1'b0;
            mem.mem_we     <= 1'b0;
            valid_out      <= 1'b1;
            WB_Out         <= wb_lat;
            Read_Data_Out  <= mem.mem_we ? 64'd0 : mem.mem_rdata;
            ALU_Result_Out <= mem.mem_addr;
            rd_out         <= rd_lat;
          end else if (timeout_hit) begin
            state       <= IDLE;
            mem.mem_req <= 1'b0;
            mem.mem_we  <= 1'b0;
            mem_err     <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/mem_access_stage.md
MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 Parameter: TIMEOUT, default 16, max WAIT cycles before a memory access is aborted; legal range 2..255.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 valid_in  input  1  EX/MEM register holds a live instruction.
REQ-005 WB  input  2  {RegWrite, MemtoReg} from EX/MEM.
REQ-006 Branch, MemWrite, MemRead  input  1 each  control from EX/MEM.
REQ-007 Adder_Result  input  64  branch target; ALU_Zero  input  1  branch condition.
REQ-008 ALU_Result  input  64  memory address or ALU value; Forward_B_Mux_Result  input  64  store data; rd  input  5  destination register.
REQ-009 PCSrc  output  1  take branch; Branch_Target  output  64  target PC.
REQ-010 mem_stall  output  1  hold EX/MEM and all upstream stages.
REQ-011 mem_req  output  1; mem_we  output  1; mem_addr  output  64; mem_wdata  output  64  data-memory request port.
REQ-012 mem_rdata  input  64; mem_ack  input  1  data-memory response.
REQ-013 mem_err  output  1  one-cycle pulse on misaligned or timed-out access.
REQ-014 WB_Out  output  2; Read_Data_Out  output  64; ALU_Result_Out  output  64; rd_out  output  5; valid_out  output  1  MEM/WB register.

Function
REQ-015 memop = valid_in & (MemRead | MemWrite); aligned = (ALU_Result[2:0] == 0).
REQ-016 PCSrc = valid_in & Branch & ALU_Zero; Branch_Target = Adder_Result; both combinational.
REQ-017 States: IDLE, WAIT; only IDLE and WAIT exist.
REQ-018 IDLE, valid_in & ~memop: next edge loads MEM/WB with WB, ALU_Result, rd, Read_Data_Out=0, valid_out=1 (latency 1).
REQ-019 IDLE, ~valid_in: next edge loads bubble (valid_out=0, WB_Out=0); other MEM/WB fields don't-care.
REQ-020 IDLE, memop & aligned: mem_stall=1 combinationally; next edge -> WAIT, latch mem_addr=ALU_Result, mem_wdata=Forward_B_Mux_Result, mem_we=MemWrite, WB, rd; set mem_req=1.
REQ-021 IDLE, memop & ~aligned: no request, mem_stall=0, next edge pulses mem_err=1 and loads bubble.
REQ-022 MemRead and MemWrite both set: treated as write.
REQ-023 WAIT: mem_req, mem_we, mem_addr, mem_wdata held stable; cycle counter increments from 0 each cycle.
REQ-024 WAIT & mem_ack: mem_stall=0 same cycle; next edge -> IDLE, mem_req=0, MEM/WB loads latched WB/rd/address, Read_Data_Out=mem_rdata on loads (0 on stores), valid_out=1.
REQ-025 WAIT & ~mem_ack: mem_stall=1.
REQ-026 WAIT, counter == TIMEOUT-1 & ~mem_ack: mem_stall=0; next edge -> IDLE, mem_req=0, mem_err pulse, bubble loaded; ack on that same cycle wins over timeout.
REQ-027 While mem_stall=1, MEM/WB loads bubble each edge (no duplicate writeback).
REQ-028 mem_ack in IDLE ignored.
REQ-029 Load-to-writeback latency = 1 + number of WAIT cycles until ack; minimum 2.

Reset
REQ-030 reset_n low: immediately state=IDLE, counter=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_err=0, all MEM/WB outputs 0.
REQ-031 Reset asserted in WAIT aborts the access; no writeback and no mem_err after release.
REQ-032 First edge after reset release behaves as IDLE.

Verification
REQ-033 ALU op valid_in=1, ALU_Result=0x2A, rd=5, WB=2'b10 -> next edge valid_out=1, ALU_Result_Out=0x2A, rd_out=5, mem_stall never high.
REQ-034 Load addr 0x100, ack 3 cycles after mem_req rises, mem_rdata=0xDEADBEEF -> mem_stall high 3 cycles, Read_Data_Out=0xDEADBEEF, valid_out=1 for one cycle.
REQ-035 Store addr 0x108 data 0x55, ack first WAIT cycle -> mem_we=1, mem_wdata=0x55, valid_out=1, Read_Data_Out=0.
REQ-036 Load addr 0x104 -> mem_req stays 0, mem_err one-cycle pulse, valid_out=0.
REQ-037 Load, never ack, TIMEOUT=16 -> mem_req high exactly 16 cycles, then mem_err pulse, bubble, mem_stall low.
REQ-038 Branch=1, ALU_Zero=1, Adder_Result=0x400 -> PCSrc=1, Branch_Target=0x400 same cycle; reset_n low mid-WAIT -> mem_req=0 immediately.
